// File: rtl/vector_checker.sv
// Response checker for test-vector runs: compares DUT output against expected
// values, counts passes/failures, captures the first mismatch and reports a verdict.
module vector_checker #(
    parameter int unsigned OUT_BITS      = 8,
    parameter int unsigned N_VECTORS     = 100,
    parameter int unsigned CNT_W         = 32,
    parameter bit          STOP_ON_ERROR = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [OUT_BITS-1:0] i_actual,
    input  logic [OUT_BITS-1:0] i_expected,
    output logic [CNT_W-1:0]    o_checked,
    output logic [CNT_W-1:0]    o_errors,
    output logic                o_mismatch,
    output logic [CNT_W-1:0]    o_first_idx,
    output logic [OUT_BITS-1:0] o_first_diff,
    output logic                o_done,
    output logic                o_pass
);

    // Vector position is tracked separately so a narrow CNT_W can wrap freely.
    localparam int unsigned    VEC_W    = (N_VECTORS > 1) ? $clog2(N_VECTORS) : 1;
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(N_VECTORS - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DONE = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              state_q;
    logic [VEC_W-1:0]    vec_cnt_q;
    logic [CNT_W-1:0]    checked_q;
    logic [CNT_W-1:0]    errors_q;
    logic [CNT_W-1:0]    first_idx_q;
    logic [OUT_BITS-1:0] first_diff_q;
    logic                mismatch_q;
    logic                have_err_q;
    logic                done_q;
    logic                pass_q;

    logic [OUT_BITS-1:0] diff_c;
    logic                mis_c;
    logic                last_c;
    logic [CNT_W-1:0]    errors_d;

    always_comb begin
        diff_c   = i_actual ^ i_expected;
        mis_c    = (i_actual != i_expected);
        last_c   = (vec_cnt_q == LAST_VEC);
        errors_d = errors_q;
        if (mis_c && (errors_q != ERR_MAX)) begin
            errors_d = errors_q + CNT_W'(1);
        end
    end

    // Checker FSM with all outputs registered alongside the state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_RUN;
            vec_cnt_q    <= '0;
            checked_q    <= '0;
            errors_q     <= '0;
            first_idx_q  <= '0;
            first_diff_q <= '0;
            mismatch_q   <= 1'b0;
            have_err_q   <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            mismatch_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (i_valid) begin
                        checked_q  <= checked_q + CNT_W'(1);
                        vec_cnt_q  <= vec_cnt_q + VEC_W'(1);
                        errors_q   <= errors_d;
                        mismatch_q <= mis_c;
                        if (mis_c && !have_err_q) begin
                            have_err_q   <= 1'b1;
                            first_idx_q  <= checked_q;
                            first_diff_q <= diff_c;
                        end
                        // Final vector wins over halting so the verdict is DONE.
                        if (last_c) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            pass_q  <= (errors_d == '0);
                        end else if (STOP_ON_ERROR && mis_c) begin
                            state_q <= ST_HALT;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b0;
                        end
                    end
                end
                ST_DONE, ST_HALT: begin
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign o_checked    = checked_q;
    assign o_errors     = errors_q;
    assign o_mismatch   = mismatch_q;
    assign o_first_idx  = first_idx_q;
    assign o_first_diff = first_diff_q;
    assign o_done       = done_q;
    assign o_pass       = pass_q;

endmodule

// File: tb/tb_vector_checker.sv
// Scoreboard bench for vector_checker: three configurations share one stimulus
// stream and are compared every cycle against a count-based reference model.
module tb_vector_checker;

    localparam int NDUT = 3;
    localparam int N_V [NDUT] = '{4, 4, 5};
    localparam int CW  [NDUT] = '{32, 32, 2};
    localparam bit STP [NDUT] = '{1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] actual;
    logic [7:0] expected;

    logic [31:0] r_checked, r_errors, r_first_idx;
    logic [7:0]  r_first_diff;
    logic        r_mismatch, r_done, r_pass;
    logic [31:0] s_checked, s_errors, s_first_idx;
    logic [7:0]  s_first_diff;
    logic        s_mismatch, s_done, s_pass;
    logic [1:0]  t_checked, t_errors, t_first_idx;
    logic [7:0]  t_first_diff;
    logic        t_mismatch, t_done, t_pass;

    always #5 clk = ~clk;

    vector_checker #(.OUT_BITS(8), .N_VECTORS(4), .CNT_W(32), .STOP_ON_ERROR(1'b0)) u_run (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_actual(actual), .i_expected(expected),
        .o_checked(r_checked), .o_errors(r_errors), .o_mismatch(r_mismatch),
        .o_first_idx(r_first_idx), .o_first_diff(r_first_diff), .o_done(r_done), .o_pass(r_pass));

    vector_checker #(.OUT_BITS(8), .N_VECTORS(4), .CNT_W(32), .STOP_ON_ERROR(1'b1)) u_stop (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_actual(actual), .i_expected(expected),
        .o_checked(s_checked), .o_errors(s_errors), .o_mismatch(s_mismatch),
        .o_first_idx(s_first_idx), .o_first_diff(s_first_diff), .o_done(s_done), .o_pass(s_pass));

    vector_checker #(.OUT_BITS(8), .N_VECTORS(5), .CNT_W(2), .STOP_ON_ERROR(1'b0)) u_sat (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_actual(actual), .i_expected(expected),
        .o_checked(t_checked), .o_errors(t_errors), .o_mismatch(t_mismatch),
        .o_first_idx(t_first_idx), .o_first_diff(t_first_diff), .o_done(t_done), .o_pass(t_pass));

    typedef struct packed {
        logic [63:0] checked;
        logic [63:0] errors;
        logic [63:0] first_idx;
        logic [7:0]  diff;
        logic        mis;
        logic        done;
        logic        pass;
    } obs_t;

    // Reference model: plain unbounded counts, reduced to the output widths on read.
    longint    m_acc   [NDUT];
    longint    m_err   [NDUT];
    longint    m_first [NDUT];
    logic [7:0] m_diff [NDUT];
    bit        m_mis   [NDUT];

    obs_t q0[$];
    obs_t q1[$];
    obs_t q2[$];

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  running = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_done(input int d);
        return (m_acc[d] >= N_V[d]) || (STP[d] && m_err[d] > 0);
    endfunction

    function automatic obs_t m_out(input int d);
        obs_t       o;
        longint     lim;
        lim         = (longint'(1) << CW[d]);
        o.checked   = 64'(m_acc[d] % lim);
        o.errors    = 64'((m_err[d] < lim - 1) ? m_err[d] : lim - 1);
        o.first_idx = 64'(m_first[d] % lim);
        o.diff      = m_diff[d];
        o.mis       = m_mis[d];
        o.done      = m_done(d);
        o.pass      = m_done(d) && (m_err[d] == 0);
        return o;
    endfunction

    task automatic m_step(input int d, input bit r, input bit v, input logic [7:0] a, input logic [7:0] e);
        m_mis[d] = 1'b0;
        if (r) begin
            m_acc[d] = 0; m_err[d] = 0; m_first[d] = 0; m_diff[d] = 8'h00;
        end else if (v && !m_done(d)) begin
            if (a != e) begin
                if (m_err[d] == 0) begin
                    m_first[d] = m_acc[d];
                    m_diff[d]  = a ^ e;
                end
                m_err[d]++;
                m_mis[d] = 1'b1;
            end
            m_acc[d]++;
        end
    endtask

    function automatic obs_t dut_obs(input int d);
        obs_t o;
        case (d)
            0: o = '{64'(r_checked), 64'(r_errors), 64'(r_first_idx), r_first_diff, r_mismatch, r_done, r_pass};
            1: o = '{64'(s_checked), 64'(s_errors), 64'(s_first_idx), s_first_diff, s_mismatch, s_done, s_pass};
            default: o = '{64'(t_checked), 64'(t_errors), 64'(t_first_idx), t_first_diff, t_mismatch, t_done, t_pass};
        endcase
        return o;
    endfunction

    // Drive one cycle of stimulus and queue the expected post-edge view of every DUT.
    task automatic step(input bit r, input bit v, input logic [7:0] a, input logic [7:0] e);
        rst = r; valid = v; actual = a; expected = e;
        for (int d = 0; d < NDUT; d++) begin
            m_step(d, r, v, a, e);
        end
        q0.push_back(m_out(0));
        q1.push_back(m_out(1));
        q2.push_back(m_out(2));
        @(negedge clk);
    endtask

    task automatic vec(input logic [7:0] a, input logic [7:0] e);
        step(1'b0, 1'b1, a, e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, $urandom_range(255), $urandom_range(255));
    endtask

    // Monitor: one observation per DUT per cycle, popped and compared after each edge.
    initial begin
        obs_t e;
        obs_t a;
        bit   have;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < NDUT; d++) begin
                have = 1'b0;
                case (d)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                endcase
                if (have) begin
                    a = dut_obs(d);
                    chk($sformatf("dut%0d.checked", d),    a.checked,   e.checked);
                    chk($sformatf("dut%0d.errors", d),     a.errors,    e.errors);
                    chk($sformatf("dut%0d.first_idx", d),  a.first_idx, e.first_idx);
                    chk($sformatf("dut%0d.first_diff", d), 64'(a.diff), 64'(e.diff));
                    chk($sformatf("dut%0d.mismatch", d),   64'(a.mis),  64'(e.mis));
                    chk($sformatf("dut%0d.done", d),       64'(a.done), 64'(e.done));
                    chk($sformatf("dut%0d.pass", d),       64'(a.pass), 64'(e.pass));
                end else if (running) begin
                    chk($sformatf("dut%0d.sb_underflow", d), 64'd1, 64'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] x;
        logic [7:0] f;
        logic [7:0] vals [4];
        vals = '{8'h10, 8'h21, 8'h70, 8'hF9};
        for (int d = 0; d < NDUT; d++) begin
            m_acc[d] = 0; m_err[d] = 0; m_first[d] = 0; m_diff[d] = 8'h00; m_mis[d] = 1'b0;
        end
        rst = 1'b1; valid = 1'b0; actual = 8'h00; expected = 8'h00;
        running = 1'b1;

        // Reset state
        step(1'b1, 1'b0, 8'h00, 8'h00);
        chk("reset.checked", 64'(r_checked), 64'd0);
        chk("reset.done", 64'(r_done), 64'd0);

        // All pass, then an extra vector after the verdict
        for (int i = 0; i < 4; i++) vec(vals[i], vals[i]);
        chk("allpass.checked", 64'(r_checked), 64'd4);
        chk("allpass.pass", 64'({r_done, r_pass}), 64'b11);
        vec(8'h55, 8'h55);
        chk("allpass.frozen", 64'(r_checked), 64'd4);

        // Single mismatch at index 2
        step(1'b1, 1'b0, 8'h00, 8'h00);
        vec(8'h01, 8'h01); vec(8'h02, 8'h02); vec(8'h08, 8'h0C);
        chk("single.pulse", 64'(r_mismatch), 64'd1);
        vec(8'h03, 8'h03);
        chk("single.pulse_end", 64'(r_mismatch), 64'd0);
        chk("single.first", {r_first_idx, 24'd0, r_first_diff}, {32'd2, 24'd0, 8'h04});
        chk("single.verdict", 64'({r_errors[3:0], r_done, r_pass}), 64'b0001_10);

        // Mismatches at 1 and 3; stop-on-error copy halts after vector 1
        step(1'b1, 1'b0, 8'h00, 8'h00);
        vec(8'h11, 8'h11); vec(8'h21, 8'h20);
        chk("stop.halt", 64'({s_checked[3:0], s_done, s_pass}), 64'b0010_10);
        vec(8'h33, 8'h33); vec(8'hC4, 8'h44);
        chk("multi.first", {r_first_idx, 24'd0, r_first_diff}, {32'd1, 24'd0, 8'h01});
        chk("multi.errors", 64'(r_errors), 64'd2);
        chk("stop.frozen", 64'(s_checked), 64'd2);

        // Gap of three idle cycles
        step(1'b1, 1'b0, 8'h00, 8'h00);
        vec(8'h01, 8'h01); vec(8'h02, 8'h02);
        repeat (3) idle();
        chk("gap.checked", 64'({r_checked[3:0], r_done}), 64'b0010_0);
        vec(8'h03, 8'h03); vec(8'h04, 8'h04);
        chk("gap.pass", 64'(r_pass), 64'd1);

        // Reset mid-run
        step(1'b1, 1'b0, 8'h00, 8'h00);
        vec(8'h0A, 8'h0A); vec(8'h0B, 8'h1B);
        step(1'b1, 1'b1, 8'h0C, 8'hCC);
        chk("midreset.zero", {r_checked, r_errors} | 64'({r_first_diff, r_mismatch, r_done, r_pass}), 64'd0);
        for (int i = 0; i < 4; i++) vec(vals[i], vals[i]);
        chk("midreset.pass", 64'(r_pass), 64'd1);

        // Saturation on the 2-bit instance
        step(1'b1, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) vec(8'(i), 8'(i) ^ 8'h80);
        chk("sat.verdict", 64'({t_errors, t_checked, t_done, t_pass}), 64'b11_01_10);

        // Randomized runs with gaps, random mismatches and occasional resets
        for (int run = 0; run < 60; run++) begin
            step(1'b1, 1'b0, 8'h00, 8'h00);
            for (int c = 0; c < 12; c++) begin
                x = 8'($urandom_range(255));
                f = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'h00;
                step(($urandom_range(40) == 0), ($urandom_range(9) < 7), x ^ f, x);
            end
        end

        running = 1'b0;
        chk("sb.drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
